// File: rtl/usb_pkg.sv
// -----------------------------------------------------------------------------
// usb_pkg
// Shared encodings for the USB device-side transaction logic. The RX decoder,
// the TX controller and the transaction scheduler all use these types.
//   rx_pkt_e    : packet kinds reported by the receiver (rx_packet)
//   tx_pkt_e    : packet kinds commanded to the transmitter (tx_packet)
//   txn_state_e : transaction scheduler states
// -----------------------------------------------------------------------------
package usb_pkg;

    typedef enum logic [2:0] {
        RX_NONE  = 3'd0,
        RX_OUT   = 3'd1,
        RX_IN    = 3'd2,
        RX_DATA0 = 3'd3,
        RX_DATA1 = 3'd4,
        RX_ACK   = 3'd5,
        RX_NAK   = 3'd6,
        RX_ERR   = 3'd7
    } rx_pkt_e;

    typedef enum logic [2:0] {
        TX_NONE  = 3'd0,
        TX_DATA0 = 3'd1,
        TX_DATA1 = 3'd2,
        TX_ACK   = 3'd3,
        TX_NAK   = 3'd4
    } tx_pkt_e;

    typedef enum logic [2:0] {
        ST_IDLE          = 3'd0,
        ST_OUT_WAIT_DATA = 3'd1,
        ST_OUT_HS        = 3'd2,
        ST_IN_DATA       = 3'd3,
        ST_IN_NAK        = 3'd4,
        ST_TX_WAIT       = 3'd5,
        ST_IN_WAIT_ACK   = 3'd6
    } txn_state_e;

    // DATA PID to transmit for a given toggle value.
    function automatic tx_pkt_e data_pid(input logic toggle);
        return toggle ? TX_DATA1 : TX_DATA0;
    endfunction

    // True for the packets after which the host must answer with a handshake.
    function automatic logic is_data_tx(input tx_pkt_e pkt);
        return (pkt == TX_DATA0) || (pkt == TX_DATA1);
    endfunction

endpackage

// File: rtl/txn_timer.sv
// -----------------------------------------------------------------------------
// txn_timer
// 8-bit response timeout counter. Held at zero while clear is high, counts
// while enable is high, and flags expired in the cycle its count equals
// rollover_val (the count then rolls back to zero).
// Ports:
//   clk, n_rst    : clock, asynchronous active-low reset
//   clear         : force the count to zero
//   enable        : advance the count by one per cycle
//   rollover_val  : terminal count
//   expired       : high while enabled and the count equals rollover_val
// -----------------------------------------------------------------------------
module txn_timer (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       clear,
    input  logic       enable,
    input  logic [7:0] rollover_val,
    output logic       expired
);

    logic [7:0] r_count;
    logic       w_at_limit;

    assign w_at_limit = (r_count == rollover_val);
    assign expired    = enable && w_at_limit;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_count <= 8'd0;
        end else if (clear) begin
            r_count <= 8'd0;
        end else if (enable) begin
            r_count <= w_at_limit ? 8'd0 : r_count + 8'd1;
        end
    end

endmodule

// File: rtl/usb_txn_scheduler.sv
// -----------------------------------------------------------------------------
// usb_txn_scheduler
// Sequences one USB transaction at a time: accepts OUT/IN tokens from the
// receiver, commands ACK/NAK/DATAx packets to the transmitter, tracks the data
// toggle and flags protocol errors.
// Optional feature: define TXN_TIMEOUT_EN to abandon a transaction when no
// response packet arrives within TIMEOUT_CYCLES clocks. Without it the wait
// states leave only on rx_done and TIMEOUT_CYCLES has no effect.
// Ports:
//   clk, n_rst        : clock, asynchronous active-low reset
//   rx_done/rx_packet : end-of-packet pulse and decoded received packet
//   tx_done           : transmitter finished the commanded packet
//   host_data_ready   : IN payload has been loaded by the host side
//   buffer_occupancy  : bytes held in the shared buffer
//   tx_start/tx_packet: transmit command pulse and packet kind (held to tx_done)
//   clear_buffer      : flush pulse for the shared buffer
//   d_mode            : transmitter owns the bus
//   txn_error         : sticky error, cleared by the next OUT or IN token
//   data_toggle       : current DATA PID (0 = DATA0)
// -----------------------------------------------------------------------------
module usb_txn_scheduler
    import usb_pkg::*;
#(
    parameter logic [7:0] TIMEOUT_CYCLES = 8'd200
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       rx_done,
    input  logic [2:0] rx_packet,
    input  logic       tx_done,
    input  logic       host_data_ready,
    input  logic [6:0] buffer_occupancy,
    output logic       tx_start,
    output logic [2:0] tx_packet,
    output logic       clear_buffer,
    output logic       d_mode,
    output logic       txn_error,
    output logic       data_toggle
);

    txn_state_e r_state;
    tx_pkt_e    r_tx_packet;
    logic       r_tx_start;
    logic       r_clear_buffer;
    logic       r_d_mode;
    logic       r_txn_error;
    logic       r_data_toggle;

    rx_pkt_e    w_rx_pkt;
    logic       w_rx_is_data;
    logic       w_rx_pid;
    logic       w_in_ready;
    logic       w_timeout;

    assign w_rx_pkt     = rx_pkt_e'(rx_packet);
    assign w_rx_is_data = (w_rx_pkt == RX_DATA0) || (w_rx_pkt == RX_DATA1);
    assign w_rx_pid     = (w_rx_pkt == RX_DATA1);
    assign w_in_ready   = host_data_ready && (buffer_occupancy != 7'd0);

`ifdef TXN_TIMEOUT_EN
    logic w_waiting;

    // The counter is held at zero outside the response-wait states, so it
    // always starts from zero on entry to one of them.
    assign w_waiting = (r_state == ST_OUT_WAIT_DATA) || (r_state == ST_IN_WAIT_ACK);

    txn_timer u_timer (
        .clk          (clk),
        .n_rst        (n_rst),
        .clear        (!w_waiting),
        .enable       (w_waiting),
        .rollover_val (TIMEOUT_CYCLES - 8'd1),
        .expired      (w_timeout)
    );
`else
    assign w_timeout = 1'b0;
`endif

    // Response packets are selected on the edge that consumes rx_done, so
    // tx_start and tx_packet are visible during the following one-cycle
    // OUT_HS / IN_DATA / IN_NAK state.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state        <= ST_IDLE;
            r_tx_packet    <= TX_NONE;
            r_tx_start     <= 1'b0;
            r_clear_buffer <= 1'b0;
            r_d_mode       <= 1'b0;
            r_txn_error    <= 1'b0;
            r_data_toggle  <= 1'b0;
        end else begin
            // NOTE: pulse outputs default low every cycle; only the branches
            // that fire them assign 1, and all state updates use <= so every
            // branch sees the pre-edge values.
            r_tx_start     <= 1'b0;
            r_clear_buffer <= 1'b0;

            case (r_state)
                ST_IDLE: begin
                    if (rx_done) begin
                        case (w_rx_pkt)
                            RX_OUT: begin
                                r_txn_error <= 1'b0;
                                r_state     <= ST_OUT_WAIT_DATA;
                            end
                            RX_IN: begin
                                r_txn_error <= 1'b0;
                                r_tx_start  <= 1'b1;
                                if (w_in_ready) begin
                                    r_tx_packet <= data_pid(r_data_toggle);
                                    r_state     <= ST_IN_DATA;
                                end else begin
                                    r_tx_packet <= TX_NAK;
                                    r_state     <= ST_IN_NAK;
                                end
                            end
                            default: ;  // stray packets are ignored in IDLE
                        endcase
                    end
                end

                ST_OUT_WAIT_DATA: begin
                    // rx_done outranks a timeout in the same cycle.
                    if (rx_done && w_rx_is_data) begin
                        r_tx_start  <= 1'b1;
                        r_tx_packet <= TX_ACK;
                        r_state     <= ST_OUT_HS;
                        if (w_rx_pid == r_data_toggle) begin
                            r_data_toggle <= ~r_data_toggle;
                        end else begin
                            // Retransmission of data already accepted: ACK it
                            // again but drop the duplicate payload.
                            r_clear_buffer <= 1'b1;
                        end
                    end else if (rx_done || w_timeout) begin
                        r_txn_error    <= 1'b1;
                        r_clear_buffer <= 1'b1;
                        r_state        <= ST_IDLE;
                    end
                end

                ST_OUT_HS, ST_IN_DATA, ST_IN_NAK: begin
                    r_d_mode <= 1'b1;
                    r_state  <= ST_TX_WAIT;
                end

                ST_TX_WAIT: begin
                    // Receiver activity is ignored while we own the bus.
                    if (tx_done) begin
                        r_d_mode    <= 1'b0;
                        r_tx_packet <= TX_NONE;
                        r_state     <= is_data_tx(r_tx_packet) ? ST_IN_WAIT_ACK : ST_IDLE;
                    end
                end

                ST_IN_WAIT_ACK: begin
                    if (rx_done && (w_rx_pkt == RX_ACK)) begin
                        r_data_toggle  <= ~r_data_toggle;
                        r_clear_buffer <= 1'b1;
                        r_state        <= ST_IDLE;
                    end else if (rx_done || w_timeout) begin
                        // Payload stays in the buffer for the host's retry.
                        r_txn_error <= 1'b1;
                        r_state     <= ST_IDLE;
                    end
                end

                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign tx_start     = r_tx_start;
    assign tx_packet    = r_tx_packet;
    assign clear_buffer = r_clear_buffer;
    assign d_mode       = r_d_mode;
    assign txn_error    = r_txn_error;
    assign data_toggle  = r_data_toggle;

endmodule

// File: tb/tb_usb_txn_scheduler.sv
// -----------------------------------------------------------------------------
// tb_usb_txn_scheduler
// Directed bench for usb_txn_scheduler. Each scenario task drives a packet
// sequence and compares outputs one cycle-step at a time, 1 ns after the
// rising edge. The timeout scenario depends on TXN_TIMEOUT_EN.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_usb_txn_scheduler;

    logic       clk = 1'b0;
    logic       n_rst = 1'b0;
    logic       rx_done = 1'b0;
    logic [2:0] rx_packet = 3'd0;
    logic       tx_done = 1'b0;
    logic       host_data_ready = 1'b0;
    logic [6:0] buffer_occupancy = 7'd0;
    logic       tx_start;
    logic [2:0] tx_packet;
    logic       clear_buffer;
    logic       d_mode;
    logic       txn_error;
    logic       data_toggle;

    int n_tests = 0;
    int n_fail  = 0;

    localparam logic [2:0] P_OUT = 3'd1, P_IN = 3'd2, P_D0 = 3'd3, P_D1 = 3'd4;
    localparam logic [2:0] P_ACK = 3'd5, P_NAK = 3'd6, P_ERR = 3'd7;
    localparam logic [2:0] T_NONE = 3'd0, T_D0 = 3'd1, T_D1 = 3'd2, T_ACK = 3'd3, T_NAK = 3'd4;

    usb_txn_scheduler #(.TIMEOUT_CYCLES(8'd200)) dut (
        .clk              (clk),
        .n_rst            (n_rst),
        .rx_done          (rx_done),
        .rx_packet        (rx_packet),
        .tx_done          (tx_done),
        .host_data_ready  (host_data_ready),
        .buffer_occupancy (buffer_occupancy),
        .tx_start         (tx_start),
        .tx_packet        (tx_packet),
        .clear_buffer     (clear_buffer),
        .d_mode           (d_mode),
        .txn_error        (txn_error),
        .data_toggle      (data_toggle)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_rx(input logic [2:0] pkt);
        rx_done   = 1'b1;
        rx_packet = pkt;
        tick();
        rx_done   = 1'b0;
        rx_packet = 3'd0;
    endtask

    task automatic pulse_tx_done();
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
    endtask

    task automatic test_reset();
        n_rst = 1'b0;
        tick();
        tick();
        n_tests++;
        if ({tx_start, tx_packet, clear_buffer, d_mode, txn_error, data_toggle} !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b want 00000000",
                     {tx_start, tx_packet, clear_buffer, d_mode, txn_error, data_toggle});
        end
        n_rst = 1'b1;
        tick();
    endtask

    task automatic test_out_ack();
        send_rx(P_OUT);
        n_tests++;
        if (tx_start !== 1'b0) begin n_fail++; $display("FAIL out_no_early_start: got %b want 0", tx_start); end
        send_rx(P_D0);
        n_tests++;
        if (tx_start !== 1'b1) begin n_fail++; $display("FAIL out_ack_start: got %b want 1", tx_start); end
        n_tests++;
        if (tx_packet !== T_ACK) begin n_fail++; $display("FAIL out_ack_pkt: got %0d want %0d", tx_packet, T_ACK); end
        n_tests++;
        if (data_toggle !== 1'b1) begin n_fail++; $display("FAIL out_ack_toggle: got %b want 1", data_toggle); end
        n_tests++;
        if (clear_buffer !== 1'b0) begin n_fail++; $display("FAIL out_ack_noclear: got %b want 0", clear_buffer); end
        tick();
        n_tests++;
        if ({tx_start, d_mode, tx_packet} !== {1'b0, 1'b1, T_ACK}) begin
            n_fail++;
            $display("FAIL out_ack_txwait: got start=%b dmode=%b pkt=%0d want 0 1 3", tx_start, d_mode, tx_packet);
        end
        pulse_tx_done();
        n_tests++;
        if ({d_mode, tx_packet} !== {1'b0, T_NONE}) begin
            n_fail++;
            $display("FAIL out_ack_done: got dmode=%b pkt=%0d want 0 0", d_mode, tx_packet);
        end
    endtask

    task automatic test_out_duplicate();
        // toggle is 1: DATA0 is a retransmission
        send_rx(P_OUT);
        send_rx(P_D0);
        n_tests++;
        if ({tx_start, tx_packet} !== {1'b1, T_ACK}) begin
            n_fail++;
            $display("FAIL dup_ack: got start=%b pkt=%0d want 1 3", tx_start, tx_packet);
        end
        n_tests++;
        if (clear_buffer !== 1'b1) begin n_fail++; $display("FAIL dup_clear: got %b want 1", clear_buffer); end
        n_tests++;
        if (data_toggle !== 1'b1) begin n_fail++; $display("FAIL dup_toggle: got %b want 1", data_toggle); end
        tick();
        n_tests++;
        if (clear_buffer !== 1'b0) begin n_fail++; $display("FAIL dup_clear_pulse: got %b want 0", clear_buffer); end
        pulse_tx_done();
        // matching DATA1 flips toggle back to 0
        send_rx(P_OUT);
        send_rx(P_D1);
        n_tests++;
        if ({tx_packet, data_toggle, clear_buffer} !== {T_ACK, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL out_data1: got pkt=%0d tog=%b clr=%b want 3 0 0", tx_packet, data_toggle, clear_buffer);
        end
        tick();
        pulse_tx_done();
    endtask

    task automatic test_in_data();
        host_data_ready  = 1'b1;
        buffer_occupancy = 7'd8;
        send_rx(P_IN);
        n_tests++;
        if ({tx_start, tx_packet} !== {1'b1, T_D0}) begin
            n_fail++;
            $display("FAIL in_data0: got start=%b pkt=%0d want 1 1", tx_start, tx_packet);
        end
        tick();
        n_tests++;
        if (d_mode !== 1'b1) begin n_fail++; $display("FAIL in_dmode: got %b want 1", d_mode); end
        pulse_tx_done();
        n_tests++;
        if ({d_mode, data_toggle, clear_buffer} !== 3'b000) begin
            n_fail++;
            $display("FAIL in_wait_ack: got dmode=%b tog=%b clr=%b want 0 0 0", d_mode, data_toggle, clear_buffer);
        end
        send_rx(P_ACK);
        n_tests++;
        if ({clear_buffer, data_toggle, txn_error} !== 3'b110) begin
            n_fail++;
            $display("FAIL in_acked: got clr=%b tog=%b err=%b want 1 1 0", clear_buffer, data_toggle, txn_error);
        end
    endtask

    task automatic test_in_nak();
        host_data_ready  = 1'b0;
        buffer_occupancy = 7'd8;
        send_rx(P_IN);
        n_tests++;
        if ({tx_start, tx_packet} !== {1'b1, T_NAK}) begin
            n_fail++;
            $display("FAIL nak_sent: got start=%b pkt=%0d want 1 4", tx_start, tx_packet);
        end
        tick();
        tick();
        n_tests++;
        if ({d_mode, tx_packet} !== {1'b1, T_NAK}) begin
            n_fail++;
            $display("FAIL nak_dmode: got dmode=%b pkt=%0d want 1 4", d_mode, tx_packet);
        end
        pulse_tx_done();
        n_tests++;
        if ({d_mode, data_toggle} !== 2'b01) begin
            n_fail++;
            $display("FAIL nak_done: got dmode=%b tog=%b want 0 1", d_mode, data_toggle);
        end
        // In IDLE a stray ACK must not act as a handshake
        send_rx(P_ACK);
        n_tests++;
        if ({clear_buffer, data_toggle, tx_start} !== 3'b010) begin
            n_fail++;
            $display("FAIL nak_idle: got clr=%b tog=%b start=%b want 0 1 0", clear_buffer, data_toggle, tx_start);
        end
        // ready but empty buffer still NAKs
        host_data_ready  = 1'b1;
        buffer_occupancy = 7'd0;
        send_rx(P_IN);
        n_tests++;
        if (tx_packet !== T_NAK) begin n_fail++; $display("FAIL nak_empty: got %0d want 4", tx_packet); end
        tick();
        pulse_tx_done();
    endtask

    task automatic test_errors();
        host_data_ready  = 1'b1;
        buffer_occupancy = 7'd8;
        send_rx(P_IN);
        n_tests++;
        if (tx_packet !== T_D1) begin n_fail++; $display("FAIL err_in_data1: got %0d want 2", tx_packet); end
        tick();
        pulse_tx_done();
        send_rx(P_NAK);
        n_tests++;
        if ({txn_error, clear_buffer, data_toggle} !== 3'b101) begin
            n_fail++;
            $display("FAIL err_host_nak: got err=%b clr=%b tog=%b want 1 0 1", txn_error, clear_buffer, data_toggle);
        end
        send_rx(P_OUT);
        n_tests++;
        if (txn_error !== 1'b0) begin n_fail++; $display("FAIL err_cleared: got %b want 0", txn_error); end
        send_rx(P_ERR);
        n_tests++;
        if ({txn_error, clear_buffer, tx_start} !== 3'b110) begin
            n_fail++;
            $display("FAIL err_bad_data: got err=%b clr=%b start=%b want 1 1 0", txn_error, clear_buffer, tx_start);
        end
    endtask

    task automatic test_tx_wait_ignores_rx();
        send_rx(P_IN);
        tick();
        send_rx(P_ACK);
        n_tests++;
        if ({d_mode, data_toggle, clear_buffer} !== 3'b110) begin
            n_fail++;
            $display("FAIL txwait_ignore: got dmode=%b tog=%b clr=%b want 1 1 0", d_mode, data_toggle, clear_buffer);
        end
        pulse_tx_done();
        send_rx(P_ACK);
        n_tests++;
        if ({data_toggle, clear_buffer} !== 2'b01) begin
            n_fail++;
            $display("FAIL txwait_then_ack: got tog=%b clr=%b want 0 1", data_toggle, clear_buffer);
        end
    endtask

    task automatic test_reset_in_tx_wait();
        send_rx(P_OUT);
        send_rx(P_D0);
        tick();
        pulse_tx_done();
        send_rx(P_IN);
        n_tests++;
        if ({tx_packet, data_toggle} !== {T_D1, 1'b1}) begin
            n_fail++;
            $display("FAIL rst_pre: got pkt=%0d tog=%b want 2 1", tx_packet, data_toggle);
        end
        tick();
        n_rst = 1'b0;
        #1;
        n_tests++;
        if ({tx_start, tx_packet, clear_buffer, d_mode, txn_error, data_toggle} !== 8'h00) begin
            n_fail++;
            $display("FAIL rst_async: got %b want 00000000",
                     {tx_start, tx_packet, clear_buffer, d_mode, txn_error, data_toggle});
        end
        tick();
        n_rst = 1'b1;
        tick();
        send_rx(P_IN);
        n_tests++;
        if ({tx_start, tx_packet} !== {1'b1, T_D0}) begin
            n_fail++;
            $display("FAIL rst_next_in: got start=%b pkt=%0d want 1 1", tx_start, tx_packet);
        end
        tick();
        pulse_tx_done();
        send_rx(P_ACK);
    endtask

    task automatic test_timeout();
`ifdef TXN_TIMEOUT_EN
        send_rx(P_OUT);
        repeat (199) tick();
        n_tests++;
        if ({txn_error, clear_buffer} !== 2'b00) begin
            n_fail++;
            $display("FAIL tmo_early: got err=%b clr=%b want 0 0", txn_error, clear_buffer);
        end
        tick();
        n_tests++;
        if ({txn_error, clear_buffer} !== 2'b11) begin
            n_fail++;
            $display("FAIL tmo_fire: got err=%b clr=%b want 1 1", txn_error, clear_buffer);
        end
        tick();
        n_tests++;
        if (clear_buffer !== 1'b0) begin n_fail++; $display("FAIL tmo_pulse: got %b want 0", clear_buffer); end
        send_rx(P_OUT);
        repeat (199) tick();
        send_rx(P_D1);
        n_tests++;
        if ({tx_start, tx_packet, txn_error} !== {1'b1, T_ACK, 1'b0}) begin
            n_fail++;
            $display("FAIL tmo_rx_priority: got start=%b pkt=%0d err=%b want 1 3 0", tx_start, tx_packet, txn_error);
        end
        tick();
        pulse_tx_done();
`else
        send_rx(P_OUT);
        repeat (300) tick();
        n_tests++;
        if ({txn_error, clear_buffer} !== 2'b00) begin
            n_fail++;
            $display("FAIL no_tmo_wait: got err=%b clr=%b want 0 0", txn_error, clear_buffer);
        end
        send_rx(P_D1);
        n_tests++;
        if ({tx_start, tx_packet} !== {1'b1, T_ACK}) begin
            n_fail++;
            $display("FAIL no_tmo_data: got start=%b pkt=%0d want 1 3", tx_start, tx_packet);
        end
        tick();
        pulse_tx_done();
`endif
    endtask

    initial begin
        test_reset();
        test_out_ack();
        test_out_duplicate();
        test_in_data();
        test_in_nak();
        test_errors();
        test_tx_wait_ignores_rx();
        test_reset_in_tx_wait();
        test_timeout();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/usb_txn_scheduler.md
USB_TXN_SCHEDULER -- requirements
Module: usb_txn_scheduler

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 8'd200, meaning clk cycles to wait for a response packet before abandoning the transaction.
REQ-002 SHALL have ports: clk  in  1  system clock, all state updates on its rising edge.
REQ-003 n_rst  in  1  reset, asynchronous, active-low.
REQ-004 rx_done  in  1  one-cycle pulse: a received packet ended; rx_packet is valid in this cycle.
REQ-005 rx_packet  in  3  decoded received packet: 0 none, 1 OUT token, 2 IN token, 3 DATA0, 4 DATA1, 5 ACK, 6 NAK, 7 error.
REQ-006 tx_done  in  1  one-cycle pulse: the transmitter finished the commanded packet.
REQ-007 host_data_ready  in  1  AHB side has loaded an IN payload into the buffer.
REQ-008 buffer_occupancy  in  7  bytes in the shared 64-byte buffer.
REQ-009 tx_start  out  1  one-cycle pulse: transmit tx_packet.
REQ-010 tx_packet  out  3  packet to send: 0 none, 1 DATA0, 2 DATA1, 3 ACK, 4 NAK; held stable from tx_start until tx_done.
REQ-011 clear_buffer  out  1  one-cycle pulse: flush the shared buffer.
REQ-012 d_mode  out  1  1 while the transmitter owns the bus.
REQ-013 txn_error  out  1  sticky error flag; cleared on the next OUT or IN token.
REQ-014 data_toggle  out  1  current expected/sent data PID (0 = DATA0).

Function
REQ-015 States SHALL be IDLE, OUT_WAIT_DATA, OUT_HS, IN_DATA, IN_NAK, TX_WAIT, IN_WAIT_ACK.
REQ-016 IDLE: rx_done with OUT -> OUT_WAIT_DATA; with IN -> IN_DATA if host_data_ready and buffer_occupancy != 0, else IN_NAK; any other packet is ignored.
REQ-017 OUT_WAIT_DATA: rx_done with DATA0/DATA1 -> OUT_HS; rx_done with any other packet, or timeout -> IDLE with txn_error=1 and a clear_buffer pulse.
REQ-018 OUT_HS: one cycle; tx_start pulse with tx_packet=ACK -> TX_WAIT; toggle flips only if the DATA PID equals data_toggle; on mismatch ACK is still sent and clear_buffer pulses (duplicate discarded).
REQ-019 IN_DATA: one cycle; tx_start with tx_packet=DATA0/DATA1 per data_toggle -> TX_WAIT, then IN_WAIT_ACK on tx_done.
REQ-020 IN_NAK: one cycle; tx_start with tx_packet=NAK -> TX_WAIT, then IDLE on tx_done.
REQ-021 TX_WAIT: d_mode=1; on tx_done -> IN_WAIT_ACK if the packet was DATA, else IDLE.
REQ-022 IN_WAIT_ACK: rx_done with ACK -> IDLE, data_toggle flips, clear_buffer pulses; NAK, other packet or timeout -> IDLE, buffer retained, toggle unchanged, txn_error=1.
REQ-023 Timeout counter SHALL be 8 bits, zeroed on entry to each waiting state, and fire when it reaches TIMEOUT_CYCLES-1; rx_done in the same cycle as timeout SHALL take priority.
REQ-024 tx_start SHALL rise exactly one cycle after the rx_done that selected the response; never asserted outside OUT_HS/IN_DATA/IN_NAK.
REQ-025 rx_done while in TX_WAIT SHALL be ignored.

Reset
REQ-026 On n_rst=0: state IDLE, tx_start=0, tx_packet=0, clear_buffer=0, d_mode=0, txn_error=0, data_toggle=0, counter=0; an in-flight transaction is abandoned without a handshake.

Configuration
REQ-027 Macro TXN_TIMEOUT_EN: defined -> timeout counter and REQ-023 behaviour present; undefined -> no counter, wait states exit only on rx_done and TIMEOUT_CYCLES is unused.

Structure
REQ-028 Packet encodings (rx_packet, tx_packet) and the state enum SHALL live in shared package usb_pkg, also used by the RX/TX controllers.
REQ-029 Timeout counter SHALL be sub-module txn_timer (clear, enable, rollover_val in; expired out).

Verification
REQ-030 OUT, then DATA0 with toggle=0 -> tx_start one cycle later with ACK, data_toggle=1, no clear_buffer.
REQ-031 OUT, then DATA0 with toggle=1 -> ACK sent, clear_buffer pulse, data_toggle stays 1.
REQ-032 IN with host_data_ready=1, occupancy=8, then tx_done and ACK -> DATA0 sent, clear_buffer pulse, data_toggle=1.
REQ-033 IN with host_data_ready=0 -> NAK sent, d_mode high until tx_done, state IDLE, toggle unchanged.
REQ-034 TXN_TIMEOUT_EN, TIMEOUT_CYCLES=200, OUT with no DATA -> after 200 cycles IDLE, txn_error=1, clear_buffer pulse; rx_done in the expiry cycle -> handled as data.
REQ-035 n_rst low during TX_WAIT -> all outputs at reset values immediately; next IN yields DATA0.
